// File: rtl/memwb_pkg.sv
// Shared definitions for the bexkat1 memory/writeback stage: instruction type
// codes, access sizes and the stage FSM states.
package memwb_pkg;

  localparam logic [3:0] T_ALU   = 4'h3;
  localparam logic [3:0] T_LOAD  = 4'h7;
  localparam logic [3:0] T_STORE = 4'h8;

  typedef enum logic [1:0] {
    MS_WORD = 2'b00,
    MS_HALF = 2'b01,
    MS_BYTE = 2'b10
  } mem_size_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUS  = 1'b1
  } memwb_state_t;

  // The unused size encoding 2'b11 behaves as a full word access.
  function automatic mem_size_t decode_size(input logic [1:0] code);
    mem_size_t size;
    case (code)
      2'b01:   size = MS_HALF;
      2'b10:   size = MS_BYTE;
      default: size = MS_WORD;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/memwb_memlane.sv
// Big-endian byte-lane steering: lane select, store-data replication and
// zero-extended load-data extraction for one access size/offset.
module memwb_memlane
  import memwb_pkg::*;
(
  input  mem_size_t   size_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  always_comb begin
    sel_o   = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (size_i)
      MS_BYTE: begin
        wdata_o = {4{wdata_i[7:0]}};
        case (addr_i)
          2'd0: begin
            sel_o   = 4'b1000;
            rdata_o = {24'h000000, rdata_i[31:24]};
          end
          2'd1: begin
            sel_o   = 4'b0100;
            rdata_o = {24'h000000, rdata_i[23:16]};
          end
          2'd2: begin
            sel_o   = 4'b0010;
            rdata_o = {24'h000000, rdata_i[15:8]};
          end
          default: begin
            sel_o   = 4'b0001;
            rdata_o = {24'h000000, rdata_i[7:0]};
          end
        endcase
      end
      MS_HALF: begin
        wdata_o = {2{wdata_i[15:0]}};
        if (addr_i[1]) begin
          sel_o   = 4'b0011;
          rdata_o = {16'h0000, rdata_i[15:0]};
        end else begin
          sel_o   = 4'b1100;
          rdata_o = {16'h0000, rdata_i[31:16]};
        end
      end
      default: begin
        sel_o   = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/memwb.sv
// bexkat1 memory-access/writeback stage: passes ALU results to the register
// file and runs one bus cycle per load/store, stalling upstream meanwhile.
module memwb
  import memwb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [63:0]   ir_i,
  input  logic [1:0]    reg_write_i,
  input  logic [DW-1:0] result_i,
  input  logic [DW-1:0] data_i,
  output logic          stall_o,
  output logic [1:0]    reg_write_o,
  output logic [3:0]    reg_write_addr,
  output logic [DW-1:0] reg_data_out,
  output logic          bus_cyc_o,
  output logic          bus_stb_o,
  output logic          bus_we_o,
  output logic [AW-1:0] bus_adr_o,
  output logic [3:0]    bus_sel_o,
  output logic [DW-1:0] bus_dat_o,
  input  logic [DW-1:0] bus_dat_i,
  input  logic          bus_ack_i
);

  memwb_state_t  state_q, state_d;
  logic [1:0]    reg_write_q, reg_write_d;
  logic [3:0]    wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [3:0]    sel_q, sel_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [3:0]    ra_q, ra_d;
  mem_size_t     size_q, size_d;
  logic [1:0]    lo_q, lo_d;

  logic [3:0]    ir_type_s;
  logic          is_mem_s;
  mem_size_t     lane_size_s;
  logic [1:0]    lane_addr_s;
  logic [3:0]    lane_sel_s;
  logic [31:0]   lane_wdata_s;
  logic [31:0]   lane_rdata_s;
  logic          unused_s;

  assign ir_type_s = ir_i[31:28];
  assign is_mem_s  = (ir_type_s == T_LOAD) || (ir_type_s == T_STORE);
  assign unused_s  = ^{ir_i[63:32], ir_i[27:26], ir_i[19:0]};

  // One lane unit serves both directions: live inputs when idle, latched access during the bus cycle.
  assign lane_size_s = (state_q == S_BUS) ? size_q : decode_size(ir_i[25:24]);
  assign lane_addr_s = (state_q == S_BUS) ? lo_q : result_i[1:0];

  memwb_memlane u_lane (
    .size_i  (lane_size_s),
    .addr_i  (lane_addr_s),
    .wdata_i (data_i),
    .rdata_i (bus_dat_i),
    .sel_o   (lane_sel_s),
    .wdata_o (lane_wdata_s),
    .rdata_o (lane_rdata_s)
  );

  always_comb begin
    state_d     = state_q;
    reg_write_d = 2'b00;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    sel_d       = sel_q;
    dat_d       = dat_q;
    ra_d        = ra_q;
    size_d      = size_q;
    lo_d        = lo_q;
    case (state_q)
      S_IDLE: begin
        if (is_mem_s) begin
          state_d = S_BUS;
          cyc_d   = 1'b1;
          we_d    = (ir_type_s == T_STORE);
          adr_d   = {result_i[AW-1:2], 2'b00};
          sel_d   = lane_sel_s;
          dat_d   = lane_wdata_s;
          ra_d    = ir_i[23:20];
          size_d  = lane_size_s;
          lo_d    = result_i[1:0];
        end else begin
          reg_write_d = reg_write_i;
          wr_addr_d   = ir_i[23:20];
          wr_data_d   = result_i;
        end
      end
      S_BUS: begin
        if (bus_ack_i) begin
          state_d = S_IDLE;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          if (!we_q) begin
            reg_write_d = 2'b11;
            wr_addr_d   = ra_q;
            wr_data_d   = lane_rdata_s;
          end else begin
            reg_write_d = 2'b00;
          end
        end else begin
          state_d = S_BUS;
        end
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      reg_write_q <= 2'b00;
      wr_addr_q   <= 4'h0;
      wr_data_q   <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      sel_q       <= 4'b0000;
      dat_q       <= '0;
      ra_q        <= 4'h0;
      size_q      <= MS_WORD;
      lo_q        <= 2'b00;
    end else begin
      state_q     <= state_d;
      reg_write_q <= reg_write_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      sel_q       <= sel_d;
      dat_q       <= dat_d;
      ra_q        <= ra_d;
      size_q      <= size_d;
      lo_q        <= lo_d;
    end
  end

  assign stall_o        = (state_q == S_BUS);
  assign reg_write_o    = reg_write_q;
  assign reg_write_addr = wr_addr_q;
  assign reg_data_out   = wr_data_q;
  assign bus_cyc_o      = cyc_q;
  assign bus_stb_o      = cyc_q;
  assign bus_we_o       = we_q;
  assign bus_adr_o      = adr_q;
  assign bus_sel_o      = sel_q;
  assign bus_dat_o      = dat_q;

endmodule

// File: tb/tb_memwb.sv
// Directed bench for memwb: ALU pass-through, loads/stores of each size,
// reset during a bus cycle and back-to-back load/ALU write-back.
module tb_memwb;
  import memwb_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [63:0] ir_i;
  logic [1:0]  reg_write_i;
  logic [31:0] result_i;
  logic [31:0] data_i;
  logic        stall_o;
  logic [1:0]  reg_write_o;
  logic [3:0]  reg_write_addr;
  logic [31:0] reg_data_out;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [31:0] bus_adr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_dat_o;
  logic [31:0] bus_dat_i;
  logic        bus_ack_i;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  memwb #(.AW(32), .DW(32)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ir_i           (ir_i),
    .reg_write_i    (reg_write_i),
    .result_i       (result_i),
    .data_i         (data_i),
    .stall_o        (stall_o),
    .reg_write_o    (reg_write_o),
    .reg_write_addr (reg_write_addr),
    .reg_data_out   (reg_data_out),
    .bus_cyc_o      (bus_cyc_o),
    .bus_stb_o      (bus_stb_o),
    .bus_we_o       (bus_we_o),
    .bus_adr_o      (bus_adr_o),
    .bus_sel_o      (bus_sel_o),
    .bus_dat_o      (bus_dat_o),
    .bus_dat_i      (bus_dat_i),
    .bus_ack_i      (bus_ack_i)
  );

  function automatic logic [63:0] mk_ir(input logic [3:0] typ, input logic [3:0] op,
                                        input logic [3:0] ra);
    return {32'h00000000, typ, op, ra, 20'h00000};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic nop();
    ir_i        = mk_ir(T_ALU, 4'h0, 4'h0);
    reg_write_i = 2'b00;
    result_i    = 32'h00000000;
    data_i      = 32'h00000000;
  endtask

  initial begin
    rst_i     = 1'b0;
    bus_ack_i = 1'b0;
    bus_dat_i = 32'h00000000;
    nop();
    step();
    step();
    check("rst_stall", stall_o, 1'b0);
    check("rst_rw", reg_write_o, 2'b00);
    check("rst_waddr", reg_write_addr, 4'h0);
    check("rst_wdata", reg_data_out, 32'h0);
    check("rst_cyc", {bus_cyc_o, bus_stb_o, bus_we_o}, 3'b000);
    check("rst_bus", {bus_adr_o, bus_sel_o}, 36'h0);
    check("rst_dat", bus_dat_o, 32'h0);
    rst_i = 1'b1;

    // 1: ALU pass-through, one-cycle latency, no stall
    ir_i = mk_ir(T_ALU, 4'h0, 4'h5); reg_write_i = 2'b11; result_i = 32'hDEADBEEF;
    step();
    check("alu_rw", reg_write_o, 2'b11);
    check("alu_waddr", reg_write_addr, 4'h5);
    check("alu_wdata", reg_data_out, 32'hDEADBEEF);
    check("alu_stall", stall_o, 1'b0);
    check("alu_cyc", bus_cyc_o, 1'b0);

    // 2: word load, two wait cycles then ack
    ir_i = mk_ir(T_LOAD, 4'h0, 4'h2); reg_write_i = 2'b00; result_i = 32'h00001000;
    step();
    check("wl_stall1", stall_o, 1'b1);
    check("wl_ctl", {bus_cyc_o, bus_stb_o, bus_we_o}, 3'b110);
    check("wl_adr", bus_adr_o, 32'h00001000);
    check("wl_sel", bus_sel_o, 4'b1111);
    check("wl_rw_bubble", reg_write_o, 2'b00);
    nop();
    step();
    check("wl_stall2", stall_o, 1'b1);
    check("wl_hold_adr", bus_adr_o, 32'h00001000);
    step();
    check("wl_stall3", stall_o, 1'b1);
    check("wl_hold_cyc", bus_cyc_o, 1'b1);
    bus_ack_i = 1'b1; bus_dat_i = 32'h12345678;
    step();
    bus_ack_i = 1'b0;
    check("wl_rw", reg_write_o, 2'b11);
    check("wl_waddr", reg_write_addr, 4'h2);
    check("wl_wdata", reg_data_out, 32'h12345678);
    check("wl_idle", {stall_o, bus_cyc_o, bus_stb_o}, 3'b000);

    // 3: byte load from offset 3
    ir_i = mk_ir(T_LOAD, 4'h2, 4'h7); result_i = 32'h00001003;
    step();
    check("bl_sel", bus_sel_o, 4'b0001);
    check("bl_adr", bus_adr_o, 32'h00001000);
    nop();
    bus_ack_i = 1'b1; bus_dat_i = 32'hAABBCCDD;
    step();
    bus_ack_i = 1'b0;
    check("bl_rw", reg_write_o, 2'b11);
    check("bl_waddr", reg_write_addr, 4'h7);
    check("bl_wdata", reg_data_out, 32'h000000DD);

    // 3b: halfword load, upper half
    ir_i = mk_ir(T_LOAD, 4'h1, 4'h6); result_i = 32'h00001001;
    step();
    check("hl_sel", bus_sel_o, 4'b1100);
    nop();
    bus_ack_i = 1'b1; bus_dat_i = 32'hAABBCCDD;
    step();
    bus_ack_i = 1'b0;
    check("hl_wdata", reg_data_out, 32'h0000AABB);

    // 4: halfword store at 0x2002
    ir_i = mk_ir(T_STORE, 4'h1, 4'h3); result_i = 32'h00002002; data_i = 32'h0000BEEF;
    step();
    check("hs_we", {bus_cyc_o, bus_stb_o, bus_we_o}, 3'b111);
    check("hs_sel", bus_sel_o, 4'b0011);
    check("hs_adr", bus_adr_o, 32'h00002000);
    check("hs_dat", bus_dat_o, 32'hBEEFBEEF);
    check("hs_rw_bus", reg_write_o, 2'b00);
    nop();
    bus_ack_i = 1'b1;
    step();
    bus_ack_i = 1'b0;
    check("hs_rw_ack", reg_write_o, 2'b00);
    check("hs_done", {stall_o, bus_cyc_o, bus_we_o}, 3'b000);

    // 4b: byte store at offset 1 replicates the low byte
    ir_i = mk_ir(T_STORE, 4'h2, 4'h3); result_i = 32'h00002001; data_i = 32'h123456A5;
    step();
    check("bs_sel", bus_sel_o, 4'b0100);
    check("bs_dat", bus_dat_o, 32'hA5A5A5A5);
    nop();
    bus_ack_i = 1'b1;
    step();
    bus_ack_i = 1'b0;

    // 5: reset during an outstanding load
    ir_i = mk_ir(T_LOAD, 4'h0, 4'h9); result_i = 32'h00004000;
    step();
    check("rl_cyc", bus_cyc_o, 1'b1);
    nop();
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
    check("rl_drop", {bus_cyc_o, bus_stb_o, stall_o}, 3'b000);
    check("rl_rw", reg_write_o, 2'b00);
    bus_ack_i = 1'b1; bus_dat_i = 32'h99999999;
    step();
    bus_ack_i = 1'b0;
    check("rl_late_ack_rw", reg_write_o, 2'b00);
    check("rl_late_ack_data", reg_data_out, 32'h0);
    check("rl_late_ack_cyc", {bus_cyc_o, stall_o}, 2'b00);

    // 6: load, then ALU right behind it with a stray ack in idle
    ir_i = mk_ir(T_LOAD, 4'h0, 4'h4); result_i = 32'h00003000;
    step();
    ir_i = mk_ir(T_ALU, 4'h0, 4'h9); reg_write_i = 2'b11; result_i = 32'h00000055;
    bus_ack_i = 1'b1; bus_dat_i = 32'hCAFE0001;
    step();
    check("bb_ld_rw", reg_write_o, 2'b11);
    check("bb_ld_waddr", reg_write_addr, 4'h4);
    check("bb_ld_wdata", reg_data_out, 32'hCAFE0001);
    step();
    check("bb_alu_rw", reg_write_o, 2'b11);
    check("bb_alu_waddr", reg_write_addr, 4'h9);
    check("bb_alu_wdata", reg_data_out, 32'h00000055);
    check("bb_stray_ack", {bus_cyc_o, stall_o}, 2'b00);
    nop();
    bus_ack_i = 1'b0;
    step();
    check("bb_no_dup", reg_write_o, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memwb.md
Name: memwb

Overview:
- Memory-access/writeback stage of the bexkat1 pipeline.
- Takes the executed instruction, its ALU result and its store data.
- Performs any load/store on the data bus.
- Drives the register-file write port back into the decode stage: write enable, address and data.
- Stalls the upstream pipeline while a bus cycle is outstanding.

Parameters:
- AW, 32, data bus address width.
- DW, 32, data bus / register width; fixed at 32, parameter exists for lint only.

Ports:
- clk_i  in  1  pipeline clock
- rst_i  in  1  reset, synchronous, active-low
- ir_i  in  64  instruction from execute; [31:28] type, [27:24] op, [23:20] ra
- reg_write_i  in  2  write-enable lanes from execute ([1] high half, [0] low half)
- result_i  in  32  ALU result; the effective address for load/store
- data_i  in  32  store data (register ra value)
- stall_o  out  1  upstream must hold all inputs when high
- reg_write_o  out  2  register-file write enable to decode
- reg_write_addr  out  4  register-file write address
- reg_data_out  out  32  register-file write data
- bus_cyc_o  out  1  bus cycle
- bus_stb_o  out  1  bus strobe
- bus_we_o  out  1  bus write
- bus_adr_o  out  AW  bus address, word aligned ([1:0]=0)
- bus_sel_o  out  4  byte lane select, big-endian
- bus_dat_o  out  32  bus write data
- bus_dat_i  in  32  bus read data
- bus_ack_i  in  1  bus acknowledge

Behaviour:
- Reset (rst_i==0 at a posedge):
  - reg_write_o=0, reg_write_addr=0, reg_data_out=0.
  - bus_cyc_o=bus_stb_o=bus_we_o=0, bus_sel_o=0, bus_adr_o=0, bus_dat_o=0.
  - state=S_IDLE, stall_o=0.
- Reset mid bus cycle drops cyc/stb at that edge. No write-back occurs for the aborted instruction.
- FSM states: S_IDLE, S_BUS.
- S_IDLE, type neither T_LOAD nor T_STORE:
  - Next edge registers reg_write_o<=reg_write_i, reg_write_addr<=ir_i[23:20], reg_data_out<=result_i.
  - Latency 1 cycle; one instruction per cycle.
- S_IDLE, type T_LOAD or T_STORE:
  - Next edge: reg_write_o<=0 (bubble); bus_adr_o<={result_i[31:2],2'b00}.
  - cyc=stb=1; we=1 for store; sel and dat latched; go to S_BUS.
- Access size from ir_i[25:24]: 00 word, 01 halfword, 10 byte, 11 treated as word.
- Lanes are big-endian:
  - byte: addr[1:0]=0→sel 1000, data[31:24]; 1→0100; 2→0010; 3→0001.
  - halfword: addr[1]=0→1100, data[31:16]; 1→0011.
  - word: 1111.
  - Misaligned halfword/word ignores the low address bits. No fault is raised.
- Store data is replicated into the selected lanes: byte → {4{data_i[7:0]}}; half → {2{data_i[15:0]}}.
- stall_o = (state==S_BUS). It is combinational from state, and is also high in the ack cycle.
- S_BUS holds cyc/stb/we/adr/sel/dat stable until bus_ack_i.
- On the bus_ack_i edge:
  - cyc=stb=we=0; state→S_IDLE.
  - Load: reg_write_o<=2'b11, reg_write_addr<=latched ra, reg_data_out<=the addressed lane zero-extended.
  - Store: reg_write_o<=0.
- While in S_BUS, reg_write_o=0 each cycle.
- Load latency: result visible the cycle after ack. Minimum 2 cycles after acceptance (ack in first S_BUS cycle).
- bus_ack_i while not in S_BUS is ignored. Inputs in S_BUS are not sampled.
- No new instruction is accepted in the ack cycle. The next instruction is taken in the first S_IDLE cycle after it.

Decomposition:
- bexkat1Def package:
  - T_LOAD, T_STORE type codes (existing).
  - New enum mem_size_t {MS_WORD, MS_HALF, MS_BYTE}.
  - New state enum memwb_state_t {S_IDLE, S_BUS}.
- One natural combinational sub-module, memlane: (size, addr[1:0], wdata, rdata) → (sel, lane-replicated wdata, zero-extended rdata). It is used for both directions and unit-testable alone.

Test Plan:
1. ALU: T_ALU ir, ra=5, reg_write_i=3, result_i=0xDEADBEEF → next cycle reg_write_o=3, addr=5, data=0xDEADBEEF; stall_o never high.
2. Word load, result_i=0x1000, ra=2, ack after 2 wait cycles:
   - adr=0x1000, sel=1111, we=0, stall_o high 3 cycles.
   - bus_dat_i=0x12345678 → cycle after ack reg_write_o=3, addr=2, data=0x12345678.
3. Byte load, addr 0x1003, bus_dat_i=0xAABBCCDD → sel=0001, reg_data_out=0x000000DD.
4. Halfword store, addr 0x2002, data_i=0x0000BEEF → we=1, sel=0011, adr=0x2000, bus_dat_o=0xBEEFBEEF; reg_write_o stays 0.
5. Reset mid load: drop rst_i low in S_BUS before ack → next edge cyc=stb=0, stall_o=0, reg_write_o=0; a later ack is ignored.
6. Back-to-back load then ALU with stray ack in S_IDLE:
   - stray ack has no effect.
   - ALU result writes back the cycle after the load's write-back; no lost or duplicated writes.
